// File: rtl/smp_serializer.sv
// Streams a block of capture-RAM samples (ring-addressed) as CHUNK_WIDTH chunks over valid/ready; chunks held while stalled.
// Per-sample valid gap is 2+RAM_LATENCY cycles; defining ILA_SMP_SER_CHECKSUM_EN appends one XOR chunk per sample.
module smp_serializer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int CHUNK_WIDTH  = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int RAM_LATENCY  = 1
) (
  input  logic                    i_clk_ILA,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_start_addr,
  input  logic [ADDR_WIDTH:0]     i_num_samples,
  input  logic                    i_msb_first,
  output logic                    o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_ram_addr,
  input  logic [SAMPLE_WIDTH-1:0] i_ram_sample,
  output logic [CHUNK_WIDTH-1:0]  o_chunk,
  output logic                    o_chunk_valid,
  input  logic                    i_chunk_ready,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int CHUNKS = (SAMPLE_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int PAD_W  = CHUNKS * CHUNK_WIDTH;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int WAIT_W = $clog2(RAM_LATENCY + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd5;
`ifdef ILA_SMP_SER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd4;
`endif

  logic [2:0]             r_state;
  logic [ADDR_WIDTH-1:0]  r_start_addr;
  logic [ADDR_WIDTH:0]    r_num;
  logic                   r_msb;
  logic [ADDR_WIDTH:0]    r_idx;
  logic [WAIT_W-1:0]      r_wait;
  logic [PAD_W-1:0]       r_shift;
  logic [CNT_W-1:0]       r_cnt;
`ifdef ILA_SMP_SER_CHECKSUM_EN
  logic [CHUNK_WIDTH-1:0] r_csum;
`endif

  logic                   w_accept;
  logic [ADDR_WIDTH:0]    w_idx_next;
  logic                   w_blk_end;
  logic                   w_last_chunk;
  logic [PAD_W-1:0]       w_sample_pad;
  logic [CHUNK_WIDTH-1:0] w_head;

  assign w_accept     = o_chunk_valid & i_chunk_ready;
  assign w_idx_next   = r_idx + 1'b1;
  assign w_blk_end    = (w_idx_next == r_num);
  assign w_last_chunk = (r_cnt == CNT_W'(CHUNKS - 1));
  assign w_sample_pad = PAD_W'(i_ram_sample);
  assign w_head       = r_msb ? r_shift[PAD_W-1 -: CHUNK_WIDTH] : r_shift[CHUNK_WIDTH-1:0];

  always_comb begin
    o_ram_rd_en   = (r_state == S_FETCH);
    o_ram_addr    = '0;
    o_chunk_valid = (r_state == S_SHIFT);
    o_chunk       = '0;
    o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    o_done        = (r_state == S_DONE);
    if (r_state == S_FETCH) o_ram_addr = r_start_addr + r_idx[ADDR_WIDTH-1:0];
    if (r_state == S_SHIFT) o_chunk = w_head;
`ifdef ILA_SMP_SER_CHECKSUM_EN
    if (r_state == S_CHK) begin
      o_chunk_valid = 1'b1;
      o_chunk       = r_csum;
    end
`endif
  end

  always_ff @(posedge i_clk_ILA) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_start_addr <= '0;
      r_num        <= '0;
      r_msb        <= 1'b0;
      r_idx        <= '0;
      r_wait       <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
`ifdef ILA_SMP_SER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_start_addr <= i_start_addr;
            r_num        <= i_num_samples;
            r_msb        <= i_msb_first;
            r_idx        <= '0;
            r_state      <= (i_num_samples == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Capture on the cycle the RAM data lands; one more cycle follows before SHIFT.
          if (r_wait == WAIT_W'(RAM_LATENCY - 1)) begin
            r_shift <= w_sample_pad;
            r_cnt   <= '0;
`ifdef ILA_SMP_SER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
          if (r_wait == WAIT_W'(RAM_LATENCY)) r_state <= S_SHIFT;
          else                                r_wait  <= r_wait + 1'b1;
        end
        S_SHIFT: begin
          if (w_accept) begin
            r_shift <= r_msb ? (r_shift << CHUNK_WIDTH) : (r_shift >> CHUNK_WIDTH);
            r_cnt   <= r_cnt + 1'b1;
`ifdef ILA_SMP_SER_CHECKSUM_EN
            r_csum  <= r_csum ^ w_head;
`endif
            if (w_last_chunk) begin
`ifdef ILA_SMP_SER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_idx   <= w_idx_next;
              r_state <= w_blk_end ? S_DONE : S_FETCH;
`endif
            end
          end
        end
`ifdef ILA_SMP_SER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) begin
            r_idx   <= w_idx_next;
            r_state <= w_blk_end ? S_DONE : S_FETCH;
          end
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smp_serializer.sv
// Bench for smp_serializer: two configurations (24/8 latency 1, 10/4 latency 2), both with a 16-entry ring.
module tb_smp_serializer;
  typedef logic [31:0] q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // configuration A: 24-bit samples, 8-bit chunks, latency 1
  logic        a_start, a_msb, a_rd_en, a_valid, a_ready, a_busy, a_done;
  logic [3:0]  a_start_addr, a_addr;
  logic [4:0]  a_num;
  logic [23:0] a_sample;
  logic [7:0]  a_chunk;
  logic [23:0] ram_a [16];

  // configuration B: 10-bit samples, 4-bit chunks, latency 2
  logic        b_start, b_msb, b_rd_en, b_valid, b_ready, b_busy, b_done;
  logic [3:0]  b_start_addr, b_addr;
  logic [4:0]  b_num;
  logic [9:0]  b_sample, b_p1;
  logic [3:0]  b_chunk;
  logic [9:0]  ram_b [16];

  smp_serializer #(.SAMPLE_WIDTH(24), .CHUNK_WIDTH(8), .ADDR_WIDTH(4), .RAM_LATENCY(1)) u_dut_a (
    .i_clk_ILA(clk), .i_reset(rst), .i_start(a_start), .i_start_addr(a_start_addr),
    .i_num_samples(a_num), .i_msb_first(a_msb), .o_ram_rd_en(a_rd_en), .o_ram_addr(a_addr),
    .i_ram_sample(a_sample), .o_chunk(a_chunk), .o_chunk_valid(a_valid),
    .i_chunk_ready(a_ready), .o_busy(a_busy), .o_done(a_done));

  smp_serializer #(.SAMPLE_WIDTH(10), .CHUNK_WIDTH(4), .ADDR_WIDTH(4), .RAM_LATENCY(2)) u_dut_b (
    .i_clk_ILA(clk), .i_reset(rst), .i_start(b_start), .i_start_addr(b_start_addr),
    .i_num_samples(b_num), .i_msb_first(b_msb), .o_ram_rd_en(b_rd_en), .o_ram_addr(b_addr),
    .i_ram_sample(b_sample), .o_chunk(b_chunk), .o_chunk_valid(b_valid),
    .i_chunk_ready(b_ready), .o_busy(b_busy), .o_done(b_done));

  always @(posedge clk) if (a_rd_en) a_sample <= ram_a[a_addr];
  always @(posedge clk) begin
    if (b_rd_en) b_p1 <= ram_b[b_addr];
    b_sample <= b_p1;
  end

  // Monitors: accepted chunks, RAM reads, done pulses, stall-stability violations
  q_t got_a, rd_a, got_b, rd_b;
  int t_a[$], t_b[$];
  int nd_a = 0, nd_b = 0, stall_a = 0, stall_b = 0;
  logic pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;
  logic [7:0] pc_a = '0;
  logic [3:0] pc_b = '0;

  always @(negedge clk) begin
    if (!rst && pv_a && !pr_a && (!a_valid || a_chunk !== pc_a)) stall_a <= stall_a + 1;
    if (a_valid && a_ready) begin got_a.push_back(32'(a_chunk)); t_a.push_back(cyc); end
    if (a_rd_en) rd_a.push_back(32'(a_addr));
    if (a_done) nd_a <= nd_a + 1;
    pv_a <= a_valid; pr_a <= a_ready; pc_a <= a_chunk;
  end

  always @(negedge clk) begin
    if (!rst && pv_b && !pr_b && (!b_valid || b_chunk !== pc_b)) stall_b <= stall_b + 1;
    if (b_valid && b_ready) begin got_b.push_back(32'(b_chunk)); t_b.push_back(cyc); end
    if (b_rd_en) rd_b.push_back(32'(b_addr));
    if (b_done) nd_b <= nd_b + 1;
    pv_b <= b_valid; pr_b <= b_ready; pc_b <= b_chunk;
  end

  // Reference: split a zero-padded sample into chunks, order by direction, optional XOR chunk
  function automatic q_t sample_chunks(input int sw, input int cw, input bit msb, input logic [31:0] val);
    q_t q;
    logic [31:0] c[$];
    logic [31:0] cs;
    int n;
    n  = (sw + cw - 1) / cw;
    cs = 0;
    for (int k = 0; k < n; k++) begin
      c.push_back((val >> (k * cw)) & ((32'd1 << cw) - 1));
      cs ^= c[k];
    end
    for (int k = 0; k < n; k++) q.push_back(msb ? c[n-1-k] : c[k]);
`ifdef ILA_SMP_SER_CHECKSUM_EN
    q.push_back(cs);
`endif
    return q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_a(input logic [3:0] addr, input int n, input bit msb, input bit rnd,
                       input bit poke, input bit sod, output int g0);
    q_t expq, tmp;
    int r0, d0, bad;
    g0 = got_a.size(); r0 = rd_a.size(); d0 = nd_a;
    for (int i = 0; i < n; i++) begin
      tmp = sample_chunks(24, 8, msb, 32'(ram_a[4'(addr + i)]));
      foreach (tmp[j]) expq.push_back(tmp[j]);
    end
    @(posedge clk); #1;
    a_start = 1'b1; a_start_addr = addr; a_num = 5'(n); a_msb = msb; a_ready = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_start_addr = 4'($urandom); a_num = 5'($urandom); a_msb = 1'($urandom);
    if (n == 0) begin
      check("a_zero_done", 32'(a_done), 1);
      check("a_zero_busy", 32'(a_busy), 0);
    end else check("a_busy_rise", 32'(a_busy), 1);
    for (int c = 0; c < 3000; c++) begin
      if (nd_a > d0) break;
      @(posedge clk); #1;
      a_start = (sod && a_done) || (poke && a_busy && ($urandom_range(0, 3) == 0));
      a_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    a_start = 1'b0; a_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("a_done_once", nd_a - d0, 1);
    check("a_idle_busy", 32'(a_busy), 0);
    check("a_rd_count", rd_a.size() - r0, n);
    bad = 0;
    for (int i = 0; i < n; i++)
      if (r0 + i >= rd_a.size() || rd_a[r0+i] !== 32'(4'(addr + i))) bad++;
    check("a_rd_addrs", bad, 0);
    check("a_chunk_count", got_a.size() - g0, expq.size());
    bad = 0;
    for (int j = 0; j < expq.size(); j++)
      if (g0 + j >= got_a.size() || got_a[g0+j] !== expq[j]) bad++;
    check("a_chunks", bad, 0);
    check("a_stall_stable", stall_a, 0);
  endtask

  task automatic run_b(input logic [3:0] addr, input int n, input bit msb, input bit rnd, output int g0);
    q_t expq, tmp;
    int r0, d0, bad;
    g0 = got_b.size(); r0 = rd_b.size(); d0 = nd_b;
    for (int i = 0; i < n; i++) begin
      tmp = sample_chunks(10, 4, msb, 32'(ram_b[4'(addr + i)]));
      foreach (tmp[j]) expq.push_back(tmp[j]);
    end
    @(posedge clk); #1;
    b_start = 1'b1; b_start_addr = addr; b_num = 5'(n); b_msb = msb; b_ready = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; b_start_addr = 4'($urandom); b_num = 5'($urandom); b_msb = 1'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if (nd_b > d0) break;
      @(posedge clk); #1;
      b_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    b_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("b_done_once", nd_b - d0, 1);
    check("b_idle_busy", 32'(b_busy), 0);
    bad = (rd_b.size() - r0 == n) ? 0 : 1;
    for (int i = 0; i < n; i++)
      if (r0 + i >= rd_b.size() || rd_b[r0+i] !== 32'(4'(addr + i))) bad++;
    check("b_rd_addrs", bad, 0);
    check("b_chunk_count", got_b.size() - g0, expq.size());
    bad = 0;
    for (int j = 0; j < expq.size(); j++)
      if (g0 + j >= got_b.size() || got_b[g0+j] !== expq[j]) bad++;
    check("b_chunks", bad, 0);
    check("b_stall_stable", stall_b, 0);
  endtask

  int g, d0, r0, ca, cb;

  initial begin
`ifdef ILA_SMP_SER_CHECKSUM_EN
    ca = 4; cb = 4;
`else
    ca = 3; cb = 3;
`endif
    rst = 1'b1;
    a_start = 1'b0; a_start_addr = '0; a_num = '0; a_msb = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_start_addr = '0; b_num = '0; b_msb = 1'b0; b_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ram_a[i] = 24'($urandom);
      ram_b[i] = 10'($urandom);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", 32'({a_valid, a_chunk, a_rd_en, a_addr, a_busy, a_done}), 0);
    check("reset_b", 32'({b_valid, b_chunk, b_rd_en, b_addr, b_busy, b_done}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LSB-first single sample; start raised on the o_done cycle must be ignored
    ram_a[0] = 24'hABCDEF;
    run_a(4'd0, 1, 1'b0, 1'b0, 1'b0, 1'b1, g);
    check("a_lsb_c0", got_a[g],   32'hEF);
    check("a_lsb_c1", got_a[g+1], 32'hCD);
    check("a_lsb_c2", got_a[g+2], 32'hAB);
`ifdef ILA_SMP_SER_CHECKSUM_EN
    check("a_lsb_csum", got_a[g+3], 32'h89);
`endif

    // MSB-first
    run_a(4'd0, 1, 1'b1, 1'b0, 1'b0, 1'b0, g);
    check("a_msb_c0", got_a[g],   32'hAB);
    check("a_msb_c1", got_a[g+1], 32'hCD);
    check("a_msb_c2", got_a[g+2], 32'hEF);

    // Ring wrap 14,15,0,1 and inter-sample gap with ready held high
    run_a(4'd14, 4, 1'b0, 1'b0, 1'b0, 1'b0, g);
    check("a_wrap_rd2", rd_a[rd_a.size()-2], 32'd0);
    check("a_gap", t_a[g+ca] - t_a[g+ca-1] - 1, 3);

    // Random blocks with random backpressure and start pulses while busy
    for (int k = 0; k < 6; k++)
      run_a(4'($urandom), $urandom_range(1, 16), 1'($urandom), 1'b1, 1'b1, 1'b0, g);

    // Empty block: done next cycle, no reads (checked inside the task)
    run_a(4'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b0, g);

    // Full ring
    run_a(4'd9, 16, 1'b1, 1'b1, 1'b1, 1'b0, g);

    // Reset while stalled in SHIFT: outputs clear, no done, no further reads
    d0 = nd_a;
    @(posedge clk); #1;
    a_ready = 1'b0; a_start = 1'b1; a_start_addr = 4'd2; a_num = 5'd3; a_msb = 1'b0;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int c = 0; c < 20 && !a_valid; c++) begin
      @(posedge clk); #1;
    end
    check("a_rst_in_shift", 32'(a_valid), 1);
    r0 = rd_a.size();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("a_rst_outputs", 32'({a_valid, a_chunk, a_rd_en, a_addr, a_busy, a_done}), 0);
    @(posedge clk); #1;
    rst = 1'b0; a_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("a_rst_no_done", nd_a - d0, 0);
    check("a_rst_idle", 32'(a_busy), 0);
    check("a_rst_no_reads", rd_a.size() - r0, 0);

    // Narrow config: 10-bit sample 0x3A5 MSB-first -> 3, A, 5
    ram_b[5] = 10'h3A5;
    run_b(4'd5, 1, 1'b1, 1'b0, g);
    check("b_msb_c0", got_b[g],   32'h3);
    check("b_msb_c1", got_b[g+1], 32'hA);
    check("b_msb_c2", got_b[g+2], 32'h5);
`ifdef ILA_SMP_SER_CHECKSUM_EN
    check("b_msb_csum", got_b[g+3], 32'hC);
`endif
    run_b(4'd7, 2, 1'b0, 1'b0, g);
    check("b_gap", t_b[g+cb] - t_b[g+cb-1] - 1, 4);
    for (int k = 0; k < 3; k++)
      run_b(4'($urandom), $urandom_range(1, 16), 1'($urandom), 1'b1, g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
